// File: rtl/counter_sequencer.sv
// Command sequencer for the 4-bit up/down/up-by-3/load counter, with a small command FIFO.
// Latency: a command pushed into an empty FIFO drives enable_ one cycle after its push edge.
// Backpressure: cmd_ready drops while the FIFO is full; a push attempted while full is ignored.

// Command FIFO: single clock, push/pop in the same cycle, synchronous flush.
// Latency: head entry is visible the cycle after the push edge.
// Backpressure: o_full blocks pushes; a pop while empty is ignored.
module counter_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == FULL_CNT);
    assign w_push     = i_push_vld & ~o_full & ~i_flush;
    assign w_pop      = i_pop & ~o_empty & ~i_flush;
    assign o_head_dat = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end
endmodule

module counter_sequencer #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [3:0]       cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_stop,
    input  logic             abort,
    input  logic             rco_,
    output logic             enable_,
    output logic [1:0]       mode_,
    output logic [3:0]       D_,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rco_cnt
);
    typedef struct packed {
        logic [1:0]       mode;
        logic [3:0]       data;
        logic [LEN_W-1:0] len;
        logic             stop;
    } cmd_t;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [1:0] MODE_LOAD = 2'b11;

    cmd_t             w_push_cmd;
    cmd_t             w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_start;
    logic             w_cmd_end;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_enable;
    logic             w_enable_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic [3:0]       r_data;
    logic [3:0]       w_data_nxt;
    logic [LEN_W-1:0] r_remain;
    logic [LEN_W-1:0] w_remain_nxt;
    logic             r_stop;
    logic             w_stop_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [7:0]       r_rco_cnt;

    assign w_push_cmd = '{mode: cmd_mode, data: cmd_data, len: cmd_len, stop: cmd_stop};

    counter_seq_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_flush    (abort),
        .i_push_vld (cmd_valid),
        .i_push_dat (w_push_cmd),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    // rco_ is one cycle late, so a stop-on-rco end lets the counter take one extra step.
    assign w_cmd_end = (r_remain == '0) | (r_stop & rco_);

    assign cmd_ready = ~w_full;
    assign enable_   = r_enable;
    assign mode_     = r_mode;
    assign D_        = r_data;
    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign rco_cnt   = r_rco_cnt;

    // State and registered outputs; abort wins over every other event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_enable  <= 1'b0;
            r_mode    <= 2'b00;
            r_data    <= 4'h0;
            r_remain  <= '0;
            r_stop    <= 1'b0;
            r_done    <= 1'b0;
            r_rco_cnt <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_enable <= w_enable_nxt;
            r_mode   <= w_mode_nxt;
            r_data   <= w_data_nxt;
            r_remain <= w_remain_nxt;
            r_stop   <= w_stop_nxt;
            r_done   <= w_done_nxt;
            if (abort) begin
                r_rco_cnt <= 8'h00;
            end else if (rco_ && r_enable && (r_rco_cnt != 8'hFF)) begin
                r_rco_cnt <= r_rco_cnt + 8'h01;
            end
        end
    end

    // Next state: leave IDLE when work is queued, return once the queue runs dry.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (!w_empty) w_state_nxt = S_RUN;
                S_RUN:   if (w_cmd_end && w_empty) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output next-values: start the head command, count down steps, or wind down.
    always_comb begin
        w_start      = 1'b0;
        w_pop        = 1'b0;
        w_enable_nxt = r_enable;
        w_mode_nxt   = r_mode;
        w_data_nxt   = r_data;
        w_remain_nxt = r_remain;
        w_stop_nxt   = r_stop;
        w_done_nxt   = 1'b0;
        if (abort) begin
            w_enable_nxt = 1'b0;
            w_mode_nxt   = 2'b00;
            w_data_nxt   = 4'h0;
            w_remain_nxt = '0;
            w_stop_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) w_start = 1'b1;
                end
                S_RUN: begin
                    if (w_cmd_end) begin
                        if (!w_empty) begin
                            w_start = 1'b1;
                        end else begin
                            w_enable_nxt = 1'b0;
                            w_mode_nxt   = 2'b00;
                            w_data_nxt   = 4'h0;
                            w_remain_nxt = '0;
                            w_stop_nxt   = 1'b0;
                            w_done_nxt   = 1'b1;
                        end
                    end else begin
                        w_remain_nxt = r_remain - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Back-to-back start keeps enable_ high so the counter value carries over.
        if (w_start) begin
            w_pop        = 1'b1;
            w_enable_nxt = 1'b1;
            w_mode_nxt   = w_head.mode;
            w_data_nxt   = w_head.data;
            w_remain_nxt = (w_head.mode == MODE_LOAD) ? '0 : w_head.len;
            w_stop_nxt   = w_head.stop;
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer, with a model of the external 4-bit counter.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: exercised by filling the command FIFO behind a long command.
module tb_counter_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_data;
    logic [3:0] cmd_len;
    logic       cmd_stop;
    logic       abort;
    logic       rco_;
    logic       enable_;
    logic [1:0] mode_;
    logic [3:0] D_;
    logic       busy;
    logic       done;
    logic [7:0] rco_cnt;

    logic [3:0] q;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    counter_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .cmd_stop  (cmd_stop),
        .abort     (abort),
        .rco_      (rco_),
        .enable_   (enable_),
        .mode_     (mode_),
        .D_        (D_),
        .busy      (busy),
        .done      (done),
        .rco_cnt   (rco_cnt)
    );

    // External counter: rco_ is registered alongside the step that wraps.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= 4'h0;
            rco_ <= 1'b0;
        end else if (enable_) begin
            case (mode_)
                2'b00: {rco_, q} <= {1'b0, q} + 5'd1;
                2'b01: begin rco_ <= (q == 4'h0); q <= q - 4'h1; end
                2'b10: {rco_, q} <= {1'b0, q} + 5'd3;
                default: begin q <= D_; rco_ <= 1'b0; end
            endcase
        end else begin
            rco_ <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] m, input logic [3:0] d, input logic [3:0] l, input logic s);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_data  = d;
        cmd_len   = l;
        cmd_stop  = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_data = 4'h0;
        cmd_len = 4'h0; cmd_stop = 1'b0; abort = 1'b0;
        #12;
        chk("rst_enable",  32'(enable_),   0);
        chk("rst_mode",    32'(mode_),     0);
        chk("rst_D",       32'(D_),        0);
        chk("rst_busy",    32'(busy),      0);
        chk("rst_done",    32'(done),      0);
        chk("rst_rco_cnt", 32'(rco_cnt),   0);
        chk("rst_ready",   32'(cmd_ready), 1);
        tick();
        reset = 1'b0;

        // T1: reset mid-RUN clears outputs without a clock; queued work is lost
        push(2'b00, 4'h0, 4'd7, 1'b0);
        push(2'b01, 4'h0, 4'd1, 1'b0);
        chk("t1_run_enable", 32'(enable_), 1);
        chk("t1_run_busy",   32'(busy),    1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t1_async_enable", 32'(enable_),   0);
        chk("t1_async_busy",   32'(busy),      0);
        chk("t1_async_mode",   32'(mode_),     0);
        chk("t1_async_rco",    32'(rco_cnt),   0);
        chk("t1_async_ready",  32'(cmd_ready), 1);
        tick();
        tick();
        chk("t1_hold_done", 32'(done), 0);
        reset = 1'b0;
        tick();
        tick();
        chk("t1_lost_enable", 32'(enable_), 0);
        chk("t1_lost_done",   32'(done),    0);

        // T2: single up command, len=3 -> four enabled cycles, then done pulse
        push(2'b00, 4'h0, 4'd3, 1'b0);
        chk("t2_latency", 32'(enable_), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_enable", 32'(enable_), 1);
            chk("t2_mode",   32'(mode_),   0);
            chk("t2_done",   32'(done),    0);
        end
        tick();
        chk("t2_end_enable", 32'(enable_), 0);
        chk("t2_end_done",   32'(done),    1);
        chk("t2_end_busy",   32'(busy),    0);
        tick();
        chk("t2_done_pulse", 32'(done), 0);

        // T3: load 0xD then up-by-3 len=1, back to back
        push(2'b11, 4'hD, 4'd0, 1'b0);
        push(2'b10, 4'h0, 4'd1, 1'b0);
        chk("t3_c1_enable", 32'(enable_), 1);
        chk("t3_c1_mode",   32'(mode_),   3);
        chk("t3_c1_D",      32'(D_),      13);
        tick();
        chk("t3_c2_enable", 32'(enable_), 1);
        chk("t3_c2_mode",   32'(mode_),   2);
        chk("t3_c2_q",      32'(q),       13);
        tick();
        chk("t3_c3_enable", 32'(enable_), 1);
        chk("t3_c3_mode",   32'(mode_),   2);
        chk("t3_c3_q",      32'(q),       0);
        tick();
        chk("t3_end_enable", 32'(enable_), 0);
        chk("t3_end_done",   32'(done),    1);
        chk("t3_end_q",      32'(q),       3);
        chk("t3_rco_cnt",    32'(rco_cnt), 1);

        // Abort while idle clears the rco count and raises no done
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_rco",  32'(rco_cnt), 0);
        chk("idle_abort_done", 32'(done),    0);

        // T4: load 0xF then up len=15 stop-on-rco -> ends after two up steps
        push(2'b11, 4'hF, 4'd0, 1'b0);
        push(2'b00, 4'h0, 4'd15, 1'b1);
        chk("t4_c1_mode", 32'(mode_), 3);
        tick();
        chk("t4_c2_mode",   32'(mode_),   0);
        chk("t4_c2_enable", 32'(enable_), 1);
        chk("t4_c2_q",      32'(q),       15);
        tick();
        chk("t4_c3_enable", 32'(enable_), 1);
        chk("t4_c3_q",      32'(q),       0);
        chk("t4_c3_rco",    32'(rco_cnt), 0);
        tick();
        chk("t4_end_enable", 32'(enable_), 0);
        chk("t4_end_done",   32'(done),    1);
        chk("t4_end_rco",    32'(rco_cnt), 1);
        chk("t4_end_q",      32'(q),       1);
        tick();
        chk("t4_done_pulse", 32'(done), 0);
        chk("t4_hold_q",     32'(q),    1);

        // T5: fill the FIFO behind a long command; the fifth push is dropped
        push(2'b00, 4'h0, 4'd15, 1'b0);
        tick();
        chk("t5_busy", 32'(busy), 1);
        for (int k = 1; k <= 5; k++) begin
            chk("t5_ready", 32'(cmd_ready), (k <= 4) ? 1 : 0);
            push(2'b01, 4'(k), 4'd0, 1'b0);
        end
        chk("t5_full", 32'(cmd_ready), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_long_mode",  32'(mode_),     0);
        chk("t5_long_ready", 32'(cmd_ready), 0);
        tick();
        chk("t5_pop_ready", 32'(cmd_ready), 1);
        chk("t5_pop_mode",  32'(mode_),     1);
        chk("t5_pop_D",     32'(D_),        1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("t5_seq_D", 32'(D_), k);
        end
        tick();
        chk("t5_end_enable", 32'(enable_), 0);
        chk("t5_end_done",   32'(done),    1);

        // T6: abort mid-RUN with three queued and a push on the same edge
        push(2'b00, 4'h0, 4'd15, 1'b0);
        tick();
        push(2'b01, 4'h1, 4'd0, 1'b0);
        push(2'b01, 4'h2, 4'd0, 1'b0);
        push(2'b01, 4'h3, 4'd0, 1'b0);
        cmd_valid = 1'b1; cmd_mode = 2'b11; cmd_data = 4'h9; cmd_len = 4'd0;
        abort = 1'b1;
        tick();
        cmd_valid = 1'b0;
        abort = 1'b0;
        chk("t6_enable", 32'(enable_),   0);
        chk("t6_busy",   32'(busy),      0);
        chk("t6_mode",   32'(mode_),     0);
        chk("t6_D",      32'(D_),        0);
        chk("t6_done",   32'(done),      0);
        chk("t6_rco",    32'(rco_cnt),   0);
        chk("t6_ready",  32'(cmd_ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_flushed_enable", 32'(enable_), 0);
            chk("t6_flushed_done",   32'(done),    0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
